uart_imem_loader: RTL

Serial program loader feeding the single-cycle RV32I core's instruction memory from a host UART link. It is the input-side counterpart of the seven-segment/PC display path: the display reports core state to the user, and this block takes a program image from the user. It receives a framed byte stream, assembles little-endian 32-bit words and writes them sequentially into instruction memory. While loading, it holds the core in reset.

---
 rtl/loader_pkg.sv | 28 ++
 rtl/uart_rx_byte.sv | 98 +++++++++
 rtl/uart_imem_loader.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// Shared types and helpers for the UART instruction-memory loader.
// Holds the load FSM and receiver state enums, the sync byte and the baud divisor function.
package loader_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA,
    ST_CHECK,
    ST_DONE
  } load_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  // Clock cycles per UART bit, rounded to nearest.
  function automatic int calc_div(input int clk_freq_hz, input int baud);
    return (clk_freq_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-FF synchronizer, mid-bit sampling, false-start rejection.
// byte_valid / frame_err pulse for one cycle after the stop-bit sample.
module uart_rx_byte
  import loader_pkg::*;
#(
  parameter int DIV = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam logic [15:0] FULL_M1 = 16'(DIV - 1);
  localparam logic [15:0] HALF_M1 = 16'(DIV / 2 - 1);

  logic        rx_meta, rx_sync, rx_prev;
  rx_state_t   state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        valid_d, err_d;

  // Line idles high, so the synchronizer resets to 1 to avoid a phantom start edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= RX_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      byte_valid <= valid_d;
      frame_err  <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (rx_prev && !rx_sync) state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_sync ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {rx_sync, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          valid_d = rx_sync;
          err_d   = !rx_sync;
          state_d = RX_IDLE;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign data_byte = shift_q;

endmodule

// File: rtl/uart_imem_loader.sv
// Loads a framed program image from UART into instruction memory, holding the core meanwhile.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte over the LEN and data bytes.
module uart_imem_loader
  import loader_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int BAUD        = 115_200,
  parameter int ADDR_W      = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_hold,
  output logic              load_done,
  output logic              load_err
);

  localparam int          DIV   = calc_div(CLK_FREQ_HZ, BAUD);
  localparam logic [16:0] DEPTH = 17'(1 << ADDR_W);
`ifdef LOADER_CHECKSUM_EN
  localparam load_state_t END_STATE = ST_CHECK;
`else
  localparam load_state_t END_STATE = ST_DONE;
`endif

  logic [7:0] rx_data;
  logic       rx_valid, rx_err;

  uart_rx_byte #(.DIV(DIV)) u_rx (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .data_byte  (rx_data),
    .byte_valid (rx_valid),
    .frame_err  (rx_err)
  );

  load_state_t       state_q, state_d;
  logic [7:0]        len_lo_q, len_lo_d;
  logic [15:0]       len_q, len_d;
  logic [16:0]       word_cnt_q, word_cnt_d;
  logic [1:0]        lane_q, lane_d;
  logic [23:0]       word_buf_q, word_buf_d;
  logic              we_d, hold_d, done_d, err_d;
  logic [ADDR_W-1:0] addr_d;
  logic [31:0]       wdata_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        chk_q, chk_d;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      len_lo_q   <= '0;
      len_q      <= '0;
      word_cnt_q <= '0;
      lane_q     <= '0;
      word_buf_q <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      core_hold  <= 1'b0;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      chk_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      len_lo_q   <= len_lo_d;
      len_q      <= len_d;
      word_cnt_q <= word_cnt_d;
      lane_q     <= lane_d;
      word_buf_q <= word_buf_d;
      imem_we    <= we_d;
      imem_addr  <= addr_d;
      imem_wdata <= wdata_d;
      core_hold  <= hold_d;
      load_done  <= done_d;
      load_err   <= err_d;
`ifdef LOADER_CHECKSUM_EN
      chk_q      <= chk_d;
`endif
    end
  end

  // Bytes fill the word buffer from the top so byte 0 ends up in bits 7:0 of the written word.
  always_comb begin
    state_d    = state_q;
    len_lo_d   = len_lo_q;
    len_d      = len_q;
    word_cnt_d = word_cnt_q;
    lane_d     = lane_q;
    word_buf_d = word_buf_q;
    we_d       = 1'b0;
    addr_d     = imem_addr;
    wdata_d    = imem_wdata;
    hold_d     = core_hold;
    done_d     = 1'b0;
    err_d      = load_err;
`ifdef LOADER_CHECKSUM_EN
    chk_d      = chk_q;
    if (rx_valid && state_q != ST_IDLE && state_q != ST_CHECK) chk_d = chk_q ^ rx_data;
`endif
    if (rx_err) err_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (rx_valid && rx_data == SYNC_BYTE) begin
          state_d    = ST_LEN_LO;
          hold_d     = 1'b1;
          err_d      = 1'b0;
          word_cnt_d = '0;
          addr_d     = '0;
          lane_d     = '0;
`ifdef LOADER_CHECKSUM_EN
          chk_d      = '0;
`endif
        end
      end
      ST_LEN_LO: begin
        if (rx_valid) begin
          len_lo_d = rx_data;
          state_d  = ST_LEN_HI;
        end
      end
      ST_LEN_HI: begin
        if (rx_valid) begin
          len_d   = {rx_data, len_lo_q};
          state_d = ({rx_data, len_lo_q} == 16'd0) ? END_STATE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (rx_valid) begin
          lane_d     = lane_q + 2'd1;
          word_buf_d = {rx_data, word_buf_q[23:8]};
          if (lane_q == 2'd3) begin
            wdata_d = {rx_data, word_buf_q};
            if (word_cnt_q < DEPTH) begin
              we_d   = 1'b1;
              addr_d = word_cnt_q[ADDR_W-1:0];
            end else begin
              err_d = 1'b1;
            end
            word_cnt_d = word_cnt_q + 17'd1;
            if (word_cnt_q + 17'd1 == {1'b0, len_q}) state_d = END_STATE;
          end
        end
      end
      ST_CHECK: begin
`ifdef LOADER_CHECKSUM_EN
        if (rx_valid) begin
          if (rx_data == chk_q) begin
            state_d = ST_DONE;
          end else begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
`else
        state_d = ST_IDLE;
`endif
      end
      ST_DONE: begin
        done_d  = 1'b1;
        hold_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule
